axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 subordinate (responder) with 32-bit data, backed by on-chip dual-port SRAM.
- Answers the AW/W/B and AR/R traffic issued by the DDR controller test initiators. Lets the initiators and the test flow run against a known-good target without external DDR.
- After reset it clears the whole SRAM, then raises `mem_ready`. `mem_ready` plays the same role as the controller's `ddr_ready`.

Parameters:
- BASE_ADDR, 32'h8100_0000, byte address of word 0.
- ADDR_WIDTH, 10, log2 of SRAM depth in 32-bit words (default depth is 1024 words).
- INIT_VALUE, 32'h0000_0000, word written to every location during clear.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ready  out  1  high once the post-reset clear has finished.
- awaddr  in  32  write burst start byte address.
- awlen  in  8  write beats minus 1.
- awsize  in  3  write beat size; must be 3'd2.
- awburst  in  2  write burst type; 2'b00 FIXED, 2'b01 INCR.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  last write beat.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr, arlen, arsize, arburst  in  32/8/3/2  read request; same rules as the AW channel.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rlast  out  1  last read beat.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
Reset values:
- All outputs are 0 during `rst`, including `mem_ready`, every ready/valid signal and `rdata`.
- `rst` asserted mid-operation aborts any burst immediately. No B or R beat is emitted for it, and the clear restarts.

Clear:
- CLEAR state writes INIT_VALUE to word 0 through word 2^ADDR_WIDTH-1, one word per cycle.
- `mem_ready` rises the cycle after the last word is written.
- `awready` and `arready` stay 0 while `mem_ready` is 0.

Address check (done at AW/AR acceptance):
- word index = (addr - BASE_ADDR) >> 2.
- The burst is legal only if all of these hold:
  - addr is at or above BASE_ADDR;
  - the end word (index + len for INCR, index for FIXED) is below 2^ADDR_WIDTH, computed at 33 bits so it cannot overflow;
  - size is 2, burst type is 00 or 01, and addr[1:0] is 0.
- Out-of-range address gives DECERR (2'b11). Any other illegal field gives SLVERR (2'b10). A legal burst gives OKAY (2'b00).
- A burst flagged as an error still completes all its handshakes. Error writes do not modify the SRAM. Error reads return `rdata` = 0.

Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: `awready` is 1. On the handshake, latch address, beat count and response; go to W_DATA.
- W_DATA: `wready` is 1. Each accepted beat writes the bytes enabled by `wstrb` (only for an OKAY burst). INCR increments the word index; FIXED holds it.
- Beat count exhausted with `wlast` high: go to W_RESP.
- `wlast` mismatch, either early or missing on the final beat: bresp becomes SLVERR unless it is already DECERR. Go to W_RESP on whichever comes first, the count or `wlast`.
- W_RESP: `bvalid` is 1 until `bready`; then return to W_IDLE.
- With `bready` held high, B arrives one cycle after the last W beat.

Read FSM (R_IDLE -> R_ADDR -> R_DATA -> R_ADDR or R_IDLE):
- R_IDLE: `arready` is 1. On the handshake, latch the request and go to R_ADDR.
- R_ADDR: present the SRAM read address (1-cycle synchronous read). Next state is R_DATA.
- R_DATA: `rvalid` is 1, with `rdata`, `rresp` and `rlast` held stable until `rready`.
- After the R handshake: go back to R_ADDR with the address advanced, or to R_IDLE if this was the last beat.
- Latency and throughput:
  - AR handshake in cycle T gives the first `rvalid` in T+2.
  - Throughput is one beat per 2 cycles.

Concurrency:
- The write and read FSMs are independent, and AW/W/B and AR/R may be in flight at the same time.
- A read and a write to the same word in the same cycle: the read returns the old data.

Decomposition:
- Shared package axi_pkg: RESP_OKAY/SLVERR/DECERR, BURST_FIXED/INCR, SIZE_4B constants, and the state enums for both FSMs.
- One sub-module, sram_dp_be: simple dual-port RAM with one write port carrying byte enables and one read port with 1-cycle registered read.

Test Plan:
- Release `rst` -> `mem_ready` = 0 for 1024 cycles, then 1. An AR to 0x8100_0FFC returns 0x0000_0000 with OKAY.
- Write 0x1212_1212 to 0x8100_0000 with wstrb 4'hC -> bresp OKAY, then a read returns 0x1212_0000.
- INCR write of awlen 3 to 0x8100_0010 with data 1,2,3,4, then an INCR read of arlen 3 -> rdata 1,2,3,4 with `rlast` only on beat 4. Hold `rready` low for 5 cycles on beat 2 -> data stays stable.
- Write to 0x8100_0FFC with awlen 1 (runs past the end of the SRAM) -> both W beats accepted, bresp DECERR, word 1023 unchanged. A read at 0x8000_0000 -> rresp DECERR, rdata 0.
- awsize 3'd3 or awburst 2'b10 -> SLVERR. `wlast` on beat 2 of an awlen 3 burst -> SLVERR, B issued the next cycle.
- Assert `rst` during beat 2 of a 4-beat read -> `rvalid` = 0 the next cycle and `mem_ready` drops; after the clear, memory reads INIT_VALUE.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared constants, FSM state types and the burst legality check
// used by the AXI SRAM responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        W_CLEAR,
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    // Range is judged at 33 bits so base/len arithmetic cannot wrap
    function automatic logic [1:0] burst_resp(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input logic [31:0] base,
        input logic [32:0] depth
    );
        logic [32:0] idx;
        logic [32:0] last;
        idx  = ({1'b0, addr} - {1'b0, base}) >> 2;
        last = idx + ((burst == BURST_FIXED) ? 33'd0 : {25'd0, len});
        if (addr < base || last >= depth)
            return RESP_DECERR;
        if (size != SIZE_4B || burst[1] || addr[1:0] != 2'b00)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI4 channel bundle between a test initiator and the SRAM responder.
interface axi_sram_responder_if;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/sram_dp_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A same-address read and write in one cycle returns the old word.
module sram_dp_be #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wbe_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wbe_i[b])
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i)
            rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by on-chip SRAM; clears the array after reset,
// then serves independent write (AW/W/B) and read (AR/R) bursts.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8100_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_ready,
    axi_sram_responder_if.slave  s
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    function automatic logic [ADDR_WIDTH-1:0] to_idx(
        input logic [31:0] a
    );
        return ADDR_WIDTH'((a - BASE_ADDR) >> 2);
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [1:0]            w_resp_q, w_resp_d;
    logic                  w_fixed_q, w_fixed_d;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_fixed_q, r_fixed_d;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_wbe;
    logic                  ram_re;
    logic [31:0]           ram_rdata;

    logic clr_done;
    logic w_end;
    logic r_end;

    assign clr_done  = (w_state_q != W_CLEAR);
    assign mem_ready = clr_done & ~rst;
    assign w_end     = (w_cnt_q == 8'd0);
    assign r_end     = (r_cnt_q == 8'd0);

    sram_dp_be #(
        .AW (ADDR_WIDTH),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .wbe_i   (ram_wbe),
        .re_i    (ram_re),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_CLEAR;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_resp_q  <= RESP_OKAY;
            w_fixed_q <= 1'b0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_resp_q  <= RESP_OKAY;
            r_fixed_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_resp_q  <= w_resp_d;
            w_fixed_q <= w_fixed_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_resp_q  <= r_resp_d;
            r_fixed_q <= r_fixed_d;
        end
    end

    // The clear pass reuses the write index as its word pointer
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_resp_d  = w_resp_q;
        w_fixed_d = w_fixed_q;
        ram_we    = 1'b0;
        ram_waddr = w_idx_q;
        ram_wdata = s.wdata;
        ram_wbe   = s.wstrb;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        s.bresp   = RESP_OKAY;
        unique case (w_state_q)
            W_CLEAR: begin
                ram_we    = 1'b1;
                ram_wdata = INIT_VALUE;
                ram_wbe   = 4'hF;
                w_idx_d   = w_idx_q + ADDR_WIDTH'(1);
                if (w_idx_q == LAST_IDX)
                    w_state_d = W_IDLE;
            end
            W_IDLE: begin
                s.awready = 1'b1;
                if (s.awvalid) begin
                    w_idx_d   = to_idx(s.awaddr);
                    w_cnt_d   = s.awlen;
                    w_resp_d  = burst_resp(s.awaddr, s.awlen,
                                           s.awsize, s.awburst,
                                           BASE_ADDR, DEPTH);
                    w_fixed_d = (s.awburst == BURST_FIXED);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s.wready = 1'b1;
                if (s.wvalid) begin
                    ram_we = (w_resp_q == RESP_OKAY);
                    if (w_end || s.wlast) begin
                        w_state_d = W_RESP;
                        if (w_end != s.wlast &&
                            w_resp_q != RESP_DECERR)
                            w_resp_d = RESP_SLVERR;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                        if (!w_fixed_q)
                            w_idx_d = w_idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            W_RESP: begin
                s.bvalid = 1'b1;
                s.bresp  = w_resp_q;
                if (s.bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_CLEAR;
        endcase
        if (rst) begin
            ram_we    = 1'b0;
            s.awready = 1'b0;
            s.wready  = 1'b0;
            s.bvalid  = 1'b0;
            s.bresp   = RESP_OKAY;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_resp_d  = r_resp_q;
        r_fixed_d = r_fixed_q;
        ram_re    = 1'b0;
        s.arready = 1'b0;
        s.rvalid  = 1'b0;
        s.rlast   = 1'b0;
        s.rresp   = RESP_OKAY;
        s.rdata   = '0;
        unique case (r_state_q)
            R_IDLE: begin
                s.arready = clr_done;
                if (clr_done && s.arvalid) begin
                    r_idx_d   = to_idx(s.araddr);
                    r_cnt_d   = s.arlen;
                    r_resp_d  = burst_resp(s.araddr, s.arlen,
                                           s.arsize, s.arburst,
                                           BASE_ADDR, DEPTH);
                    r_fixed_d = (s.arburst == BURST_FIXED);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                ram_re    = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                s.rvalid = 1'b1;
                s.rlast  = r_end;
                s.rresp  = r_resp_q;
                if (r_resp_q == RESP_OKAY)
                    s.rdata = ram_rdata;
                if (s.rready) begin
                    if (r_end) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q - 8'd1;
                        r_state_d = R_ADDR;
                        if (!r_fixed_q)
                            r_idx_d = r_idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rst) begin
            ram_re    = 1'b0;
            s.arready = 1'b0;
            s.rvalid  = 1'b0;
            s.rlast   = 1'b0;
            s.rresp   = RESP_OKAY;
            s.rdata   = '0;
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: single-beat vector table
// plus hand-written burst, latency, back-pressure and reset sequences.
module tb_axi_sram_responder;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_ready;

    axi_sram_responder_if bus();

    axi_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ready (mem_ready),
        .s         (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] waddr;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [2:0]  rsize;
        logic [1:0]  rburst;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        bus.awaddr  = a;
        bus.awlen   = len;
        bus.awsize  = sz;
        bus.awburst = bt;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 2000) begin step(); n++; end
        chk("awready", 32'(bus.awready), 32'd1);
        step();
        bus.awvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] st,
                         input logic last);
        int n = 0;
        bus.wdata  = d;
        bus.wstrb  = st;
        bus.wlast  = last;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 100) begin step(); n++; end
        chk("wready", 32'(bus.wready), 32'd1);
        step();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic bget(output logic [1:0] resp);
        int n = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 100) begin step(); n++; end
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        bus.araddr  = a;
        bus.arlen   = len;
        bus.arsize  = sz;
        bus.arburst = bt;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 2000) begin step(); n++; end
        chk("arready", 32'(bus.arready), 32'd1);
        step();
        bus.arvalid = 1'b0;
    endtask

    task automatic rget(output logic [31:0] d, output logic [1:0] resp,
                        output logic last);
        int n = 0;
        bus.rready = 1'b1;
        while (!bus.rvalid && n < 100) begin step(); n++; end
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        d    = bus.rdata;
        resp = bus.rresp;
        last = bus.rlast;
        step();
        bus.rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        logic        l;
        int          n;

        vt[0] = '{32'h8100_0000, 3'd2, 2'b01, 32'h1212_1212, 4'hC,
                  RESP_OKAY, 32'h8100_0000, 3'd2, 2'b01,
                  32'h1212_0000, RESP_OKAY};
        vt[1] = '{32'h8100_0004, 3'd2, 2'b01, 32'hA5A5_A5A5, 4'hF,
                  RESP_OKAY, 32'h8100_0004, 3'd2, 2'b01,
                  32'hA5A5_A5A5, RESP_OKAY};
        vt[2] = '{32'h8100_0008, 3'd3, 2'b01, 32'hFFFF_FFFF, 4'hF,
                  RESP_SLVERR, 32'h8100_0008, 3'd2, 2'b01,
                  32'h0000_0000, RESP_OKAY};
        vt[3] = '{32'h8100_000C, 3'd2, 2'b10, 32'hFFFF_FFFF, 4'hF,
                  RESP_SLVERR, 32'h8100_000C, 3'd2, 2'b10,
                  32'h0000_0000, RESP_SLVERR};
        vt[4] = '{32'h8100_0002, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF,
                  RESP_SLVERR, 32'h8100_0000, 3'd2, 2'b01,
                  32'h1212_0000, RESP_OKAY};
        vt[5] = '{32'h8000_0000, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF,
                  RESP_DECERR, 32'h8000_0000, 3'd2, 2'b01,
                  32'h0000_0000, RESP_DECERR};
        vt[6] = '{32'h8100_1000, 3'd2, 2'b00, 32'hFFFF_FFFF, 4'hF,
                  RESP_DECERR, 32'h8100_0FFC, 3'd2, 2'b01,
                  32'h0000_0000, RESP_OKAY};
        vt[7] = '{32'h8100_0FFC, 3'd2, 2'b00, 32'hDEAD_BEEF, 4'h3,
                  RESP_OKAY, 32'h8100_0FFC, 3'd2, 2'b00,
                  32'h0000_BEEF, RESP_OKAY};
        vt[8] = '{32'h8100_0004, 3'd2, 2'b01, 32'h0000_5A00, 4'h2,
                  RESP_OKAY, 32'h8100_0004, 3'd2, 2'b01,
                  32'hA5A5_5AA5, RESP_OKAY};

        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_ready_valid",
            32'({bus.awready, bus.wready, bus.bvalid,
                 bus.arready, bus.rvalid}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);

        // clear length and gating
        rst = 1'b0;
        chk("clr_aw_ar_ready",
            32'({bus.awready, bus.arready}), 32'd0);
        n = 0;
        while (!mem_ready && n < 3000) begin step(); n++; end
        chk("clear_cycles", n, 32'd1024);
        ar(32'h8100_0FFC, 8'd0, 3'd2, BURST_INCR);
        rget(d, rs, l);
        chk("clr_rdata", d, INIT_VALUE_TB());
        chk("clr_rresp", 32'(rs), 32'(RESP_OKAY));

        // single-beat vector table
        for (int i = 0; i < 9; i++) begin
            aw(vt[i].waddr, 8'd0, vt[i].wsize, vt[i].wburst);
            wbeat(vt[i].wdata, vt[i].wstrb, 1'b1);
            bget(rs);
            chk($sformatf("v%0d_bresp", i), 32'(rs), 32'(vt[i].bresp));
            ar(vt[i].raddr, 8'd0, vt[i].rsize, vt[i].rburst);
            rget(d, rs, l);
            chk($sformatf("v%0d_rdata", i), d, vt[i].rdata);
            chk($sformatf("v%0d_rresp", i), 32'(rs), 32'(vt[i].rresp));
            chk($sformatf("v%0d_rlast", i), 32'(l), 32'd1);
        end

        // INCR burst write / read with back-pressure on beat 2
        aw(32'h8100_0010, 8'd3, 3'd2, BURST_INCR);
        for (int i = 0; i < 4; i++)
            wbeat(32'(i + 1), 4'hF, i == 3);
        bget(rs);
        chk("incr_bresp", 32'(rs), 32'(RESP_OKAY));
        ar(32'h8100_0010, 8'd3, 3'd2, BURST_INCR);
        chk("r_lat_t1", 32'(bus.rvalid), 32'd0);
        step();
        chk("r_lat_t2", 32'(bus.rvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                n = 0;
                while (!bus.rvalid && n < 100) begin step(); n++; end
                for (int k = 0; k < 5; k++) begin
                    chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
                    chk("hold_rdata", bus.rdata, 32'd2);
                    step();
                end
            end
            rget(d, rs, l);
            chk($sformatf("incr_rdata%0d", i), d, 32'(i + 1));
            chk($sformatf("incr_rlast%0d", i), 32'(l), 32'(i == 3));
        end

        // burst running past the end of the array
        aw(32'h8100_0FFC, 8'd1, 3'd2, BURST_INCR);
        wbeat(32'h1111_1111, 4'hF, 1'b0);
        wbeat(32'h2222_2222, 4'hF, 1'b1);
        bget(rs);
        chk("oob_bresp", 32'(rs), 32'(RESP_DECERR));
        ar(32'h8100_0FFC, 8'd0, 3'd2, BURST_INCR);
        rget(d, rs, l);
        chk("oob_word1023", d, 32'h0000_BEEF);

        // early wlast: B one cycle after the last beat
        aw(32'h8100_0020, 8'd3, 3'd2, BURST_INCR);
        bus.bready = 1'b1;
        wbeat(32'h0000_0001, 4'hF, 1'b0);
        wbeat(32'h0000_0002, 4'hF, 1'b1);
        chk("early_bvalid", 32'(bus.bvalid), 32'd1);
        chk("early_bresp", 32'(bus.bresp), 32'(RESP_SLVERR));
        step();
        bus.bready = 1'b0;
        chk("early_idle", 32'(bus.awready), 32'd1);

        // missing wlast on the final beat
        aw(32'h8100_0030, 8'd1, 3'd2, BURST_INCR);
        wbeat(32'h0000_0003, 4'hF, 1'b0);
        wbeat(32'h0000_0004, 4'hF, 1'b0);
        bget(rs);
        chk("nolast_bresp", 32'(rs), 32'(RESP_SLVERR));

        // reset in the middle of a read burst
        ar(32'h8100_0010, 8'd3, 3'd2, BURST_INCR);
        rget(d, rs, l);
        chk("abort_beat1", d, 32'd1);
        n = 0;
        while (!bus.rvalid && n < 100) begin step(); n++; end
        chk("abort_beat2_valid", 32'(bus.rvalid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
        chk("abort_mem_ready", 32'(mem_ready), 32'd0);
        n = 0;
        while (!mem_ready && n < 3000) begin step(); n++; end
        chk("abort_reclear", n, 32'd1024);
        ar(32'h8100_0010, 8'd0, 3'd2, BURST_INCR);
        rget(d, rs, l);
        chk("abort_init", d, INIT_VALUE_TB());
        ar(32'h8100_0000, 8'd0, 3'd2, BURST_INCR);
        rget(d, rs, l);
        chk("abort_init0", d, INIT_VALUE_TB());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [31:0] INIT_VALUE_TB();
        return 32'h0000_0000;
    endfunction

endmodule
